inst_display_scan: RTL

Consumer side of the instruction text windows. It takes the 40-bit, 8-character window that the instruction generators shift one 5-bit character code into per tick. It decodes each code to a seven-segment glyph and time-multiplexes the eight glyphs onto a common-anode 8-digit display. The window is captured once per scan frame, so a mid-frame shift never tears the displayed text.

---
 rtl/inst_display_scan.sv | 136 +++++++++++++
 1 files changed

// File: rtl/inst_display_scan.sv
// Eight-digit seven-segment scanner for the instruction text window.
// The window is latched once per frame so the text never tears mid-scan.
module inst_display_scan #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_CYC   = 1000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        en,
    input  logic [39:0] instruction,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] p_q, p_d;
    logic [2:0]    d_q, d_d;
    logic [39:0]   frame_q, frame_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_done_q, frame_done_d;

    logic          capture;
    logic          blank;
    logic [39:0]   src;
    logic [4:0]    ch;

    // Active-high gfedcba glyph for a 5-bit character code.
    function automatic logic [6:0] font(input logic [4:0] c);
        logic [6:0] g;
        case (c)
            5'd0:    g = 7'h00;
            5'd1:    g = 7'h77;
            5'd2:    g = 7'h7C;
            5'd3:    g = 7'h39;
            5'd4:    g = 7'h5E;
            5'd5:    g = 7'h79;
            5'd6:    g = 7'h71;
            5'd7:    g = 7'h3D;
            5'd8:    g = 7'h76;
            5'd9:    g = 7'h30;
            5'd10:   g = 7'h1E;
            5'd11:   g = 7'h75;
            5'd12:   g = 7'h38;
            5'd13:   g = 7'h15;
            5'd14:   g = 7'h54;
            5'd15:   g = 7'h5C;
            5'd16:   g = 7'h73;
            5'd17:   g = 7'h67;
            5'd18:   g = 7'h50;
            5'd19:   g = 7'h6D;
            5'd20:   g = 7'h78;
            5'd21:   g = 7'h3E;
            5'd22:   g = 7'h1C;
            5'd23:   g = 7'h2A;
            5'd24:   g = 7'h76;
            5'd25:   g = 7'h6E;
            5'd26:   g = 7'h5B;
            default: g = 7'h40;
        endcase
        return g;
    endfunction

    generate
        if (BLANK_CYC == 0) begin : g_noblank
            assign blank = 1'b0;
        end else begin : g_blank
            assign blank = (p_q < PW'(BLANK_CYC));
        end
    endgenerate

    assign capture = en && (p_q == '0) && (d_q == 3'd0);
    // On the capture cycle the glyph comes from the window being latched.
    assign src     = capture ? instruction : frame_q;

    always_comb begin
        ch = src[4:0];
        for (int i = 1; i < 8; i++) begin
            if (d_q == 3'(i)) ch = src[5*i +: 5];
        end
    end

    always_comb begin
        p_d          = p_q;
        d_d          = d_q;
        frame_d      = frame_q;
        an_d         = 8'hFF;
        seg_d        = 7'h7F;
        frame_done_d = 1'b0;
        if (!en) begin
            p_d = '0;
            d_d = 3'd0;
        end else begin
            if (capture) begin
                frame_d      = instruction;
                frame_done_d = 1'b1;
            end
            if (p_q == P_LAST) begin
                p_d = '0;
                d_d = d_q + 3'd1;
            end else begin
                p_d = p_q + PW'(1);
            end
            if (!blank) begin
                an_d  = ~(8'd1 << d_q);
                seg_d = ~font(ch);
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            p_q          <= '0;
            d_q          <= 3'd0;
            frame_q      <= 40'd0;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
            frame_done_q <= 1'b0;
        end else begin
            p_q          <= p_d;
            d_q          <= d_d;
            frame_q      <= frame_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule
